seq_divider: RTL

Multi-cycle restoring integer divider. It is the parametrised successor to the team's single-mode 16-bit divider and adds per-operation signed/unsigned mode, configurable bits-per-cycle, valid/ready handshakes on both sides, and defined divide-by-zero and signed-overflow results. It sits beside the ALU and is shared by the execute stage. It holds one operation in flight.

---
 rtl/seq_divider.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring integer divider with signed/unsigned
// modes, configurable quotient bits per cycle, and valid/ready handshakes.
// Holds one operation in flight. Divide-by-zero and the signed
// most-negative / -1 case bypass the iteration and take a fixed result.
module seq_divider #(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] numer,
    input  logic [WIDTH-1:0] denom,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    // Number of CALC cycles for a full division.
    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Captured operation context.
    logic             q_neg;       // quotient must be negated in FIX
    logic             r_neg;       // remainder must be negated in FIX
    logic             dbz_pend;    // operation is a divide by zero
    logic             ovf_pend;    // operation is signed overflow
    logic [WIDTH-1:0] numer_raw;   // original dividend, for the fast-path results
    logic [WIDTH-1:0] dvs_q;       // divisor magnitude

    // Iteration registers: quo_q starts as the dividend magnitude and its
    // MSBs are shifted into the partial remainder while quotient bits fill
    // in from the LSB.
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;

    // Accept-time operand preparation.
    logic             accept;
    logic             numer_neg;
    logic             denom_neg;
    logic [WIDTH-1:0] numer_abs;
    logic [WIDTH-1:0] denom_abs;
    logic             is_dbz_in;
    logic             is_ovf_in;

    // Cascade results for one CALC cycle.
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // Ready only in IDLE and never while reset is held.
    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;

    // Sign handling applies only to signed operations; unsigned operands
    // pass through raw with both signs zero.
    assign numer_neg = in_signed && numer[WIDTH-1];
    assign denom_neg = in_signed && denom[WIDTH-1];
    assign numer_abs = numer_neg ? -numer : numer;
    assign denom_abs = denom_neg ? -denom : denom;
    assign is_dbz_in = (denom == '0);
    assign is_ovf_in = in_signed && (numer == MIN_NEG) && (denom == '1);

    // BITS_PER_CYCLE restoring steps chained combinationally. The WIDTH+1
    // bit difference carries one guard bit: since the shifted partial
    // remainder is below 2*divisor, the difference always fits and its top
    // bit is the borrow.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch,
        // and blocking '=' lets each step see the previous step's result.
        rem_nxt = rem_q;
        quo_nxt = quo_q;
        shifted = '0;
        diff    = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            shifted = {rem_nxt, quo_nxt[WIDTH-1]};
            diff    = shifted - {1'b0, dvs_q};
            if (!diff[WIDTH]) begin
                rem_nxt = diff[WIDTH-1:0];
                quo_nxt = {quo_nxt[WIDTH-2:0], 1'b1};
            end else begin
                rem_nxt = shifted[WIDTH-1:0];
                quo_nxt = {quo_nxt[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Control FSM, iteration datapath and registered results.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking '<=' so every register
        // updates from the values present before the edge.
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dbz_pend    <= 1'b0;
            ovf_pend    <= 1'b0;
            numer_raw   <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        q_neg       <= numer_neg ^ denom_neg;
                        r_neg       <= numer_neg;
                        dbz_pend    <= is_dbz_in;
                        ovf_pend    <= is_ovf_in;
                        numer_raw   <= numer;
                        dvs_q       <= denom_abs;
                        rem_q       <= '0;
                        quo_q       <= numer_abs;
                        cnt         <= CNT_LOAD;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                        state       <= (is_dbz_in || is_ovf_in) ? FIX : CALC;
                    end
                end

                CALC: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt   <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= FIX;
                    end
                end

                FIX: begin
                    if (dbz_pend) begin
                        quotient    <= '1;
                        remainder   <= numer_raw;
                        div_by_zero <= 1'b1;
                    end else if (ovf_pend) begin
                        quotient  <= numer_raw;
                        remainder <= '0;
                        overflow  <= 1'b1;
                    end else begin
                        // Truncating division: remainder follows the dividend sign.
                        quotient  <= q_neg ? -quo_q : quo_q;
                        remainder <= r_neg ? -rem_q : rem_q;
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
